// File: rtl/sseg_display_arbiter_pkg.sv
// Shared types and constants for the hex-display arbiter.
// State encodings are fixed so waveforms read the same across builds.
package sseg_display_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_KEEP = 2'd2
    } arb_state_e;

    // disp_hex_mux decimal points are active-low, so all-ones is "all off"
    localparam logic [3:0] DP_OFF = 4'b1111;

    // Distance of idx from ptr walking upward with wrap, used to find the first requester at/after ptr
    function automatic int rr_dist(input int idx, input int ptr, input int n);
        return (idx >= ptr) ? (idx - ptr) : (idx + n - ptr);
    endfunction

endpackage

// File: rtl/sseg_display_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr, optionally skipping the owner.
// Zero latency; no backpressure, result is valid whenever any eligible request is present.
module sseg_display_arbiter_rr_pick
    import sseg_display_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PW    = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PW-1:0]    ptr_i,
    input  logic             excl_i,
    input  logic [PW-1:0]    owner_i,
    output logic             vld_o,
    output logic [PW-1:0]    idx_o
);

    int best_dist;

    always_comb begin
        vld_o     = 1'b0;
        idx_o     = '0;
        best_dist = N_REQ;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_i[i] && !(excl_i && (owner_i == PW'(i))) &&
                (rr_dist(i, int'(ptr_i), N_REQ) < best_dist)) begin
                best_dist = rr_dist(i, int'(ptr_i), N_REQ);
                vld_o     = 1'b1;
                idx_o     = PW'(i);
            end
        end
    end

endmodule

// File: rtl/sseg_display_arbiter.sv
// Round-robin owner of the 4-digit hex display: grant 1 cycle after req, digits 1 cycle after grant.
// No backpressure (level requests); define SSEG_ARB_SRC_DP_EN to show the owner index on the dots.
module sseg_display_arbiter
    import sseg_display_arbiter_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int HOLD_CYC = 50_000_000,
    parameter int HOLD_W   = 26
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [16*N_REQ-1:0]  val,
    input  logic [4*N_REQ-1:0]   dp,
    output logic [N_REQ-1:0]     grant,
    output logic [3:0]           hex3,
    output logic [3:0]           hex2,
    output logic [3:0]           hex1,
    output logic [3:0]           hex0,
    output logic [3:0]           dp_out,
    output logic                 busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_e        state_q, state_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [15:0]       hex_q, hex_d;
    logic [3:0]        dp_q, dp_d;
    logic              busy_q, busy_d;

    logic              pick_vld;
    logic [PW-1:0]     pick_idx;
    logic              hold_done;
    logic              owner_req;
    logic              take;

    // While someone owns the display only *other* requesters may take it over
    sseg_display_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .excl_i  (state_q != ST_IDLE),
        .owner_i (owner_q),
        .vld_o   (pick_vld),
        .idx_o   (pick_idx)
    );

    assign hold_done = (cnt_q == HOLD_W'(HOLD_CYC - 1));
    assign owner_req = |(req & grant_q);

    always_comb begin
        take    = 1'b0;
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;

        case (state_q)
            ST_IDLE: take = pick_vld;
            ST_HOLD: begin
                if (hold_done) begin
                    if (pick_vld) begin
                        take = 1'b1;
                    end else if (owner_req) begin
                        state_d = ST_KEEP;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_KEEP: begin
                if (pick_vld) begin
                    take = 1'b1;
                end else if (!owner_req) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase

        if (take) begin
            state_d           = ST_HOLD;
            owner_d           = pick_idx;
            ptr_d             = (pick_idx == PW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
            cnt_d             = '0;
            grant_d           = '0;
            grant_d[pick_idx] = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // Digits track the current owner live; in IDLE the last picture stays up
    always_comb begin
        hex_d = hex_q;
        dp_d  = dp_q;
        if (state_q != ST_IDLE) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (owner_q == PW'(i)) begin
                    hex_d = val[16*i +: 16];
`ifndef SSEG_ARB_SRC_DP_EN
                    dp_d  = dp[4*i +: 4];
`endif
                end
            end
        end
`ifdef SSEG_ARB_SRC_DP_EN
        dp_d = busy_d ? {1'b0, ~(3'(owner_d))} : DP_OFF;
`endif
    end

`ifdef SSEG_ARB_SRC_DP_EN
    logic dp_unused;
    assign dp_unused = ^dp;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            hex_q   <= '0;
            dp_q    <= DP_OFF;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            hex_q   <= hex_d;
            dp_q    <= dp_d;
            busy_q  <= busy_d;
        end
    end

    assign grant  = grant_q;
    assign hex3   = hex_q[15:12];
    assign hex2   = hex_q[11:8];
    assign hex1   = hex_q[7:4];
    assign hex0   = hex_q[3:0];
    assign dp_out = dp_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_sseg_display_arbiter.sv
// Directed bench for the display arbiter with N_REQ=4 and a 4-cycle dwell.
module tb_sseg_display_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [3:0]  req = '0;
    logic [63:0] val = '0;
    logic [15:0] dp = 16'hFFFF;
    logic [3:0]  grant;
    logic [3:0]  hex3, hex2, hex1, hex0;
    logic [3:0]  dp_out;
    logic        busy;
    logic [15:0] hex_all;

    int checks = 0;
    int failures = 0;

    assign hex_all = {hex3, hex2, hex1, hex0};

    always #5 clk = ~clk;

    sseg_display_arbiter #(
        .N_REQ    (4),
        .HOLD_CYC (4),
        .HOLD_W   (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .val     (val),
        .dp      (dp),
        .grant   (grant),
        .hex3    (hex3),
        .hex2    (hex2),
        .hex1    (hex1),
        .hex0    (hex0),
        .dp_out  (dp_out),
        .busy    (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req     = '0;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #1;
        reset_n = 1'b0;
        #2;
        checks++;
        if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        checks++;
        if (hex_all !== 16'h0000) begin failures++; $display("FAIL reset_hex got=%h exp=0000", hex_all); end
        checks++;
        if (dp_out !== 4'b1111) begin failures++; $display("FAIL reset_dp got=%b exp=1111", dp_out); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        val[31:16] = 16'h12AB;
        req = 4'b0010;
        tick();
        checks++;
        if (grant !== 4'b0010 || busy !== 1'b1) begin
            failures++; $display("FAIL single_grant got=%b/%b exp=0010/1", grant, busy);
        end
        tick();
        checks++;
        if (hex_all !== 16'h12AB) begin failures++; $display("FAIL single_hex got=%h exp=12ab", hex_all); end
        repeat (6) tick();
        checks++;
        if (grant !== 4'b0010 || busy !== 1'b1) begin
            failures++; $display("FAIL single_keep got=%b/%b exp=0010/1", grant, busy);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            failures++; $display("FAIL single_drop got=%b/%b exp=0000/0", grant, busy);
        end
        checks++;
        if (hex_all !== 16'h12AB) begin failures++; $display("FAIL single_idle_hex got=%h exp=12ab", hex_all); end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_g [16];
        for (int c = 0; c < 16; c++) begin
            if (c < 4)       exp_g[c] = 4'b0001;
            else if (c < 8)  exp_g[c] = 4'b0010;
            else if (c < 12) exp_g[c] = 4'b1000;
            else             exp_g[c] = 4'b0001;
        end
        do_reset();
        val = {16'hD333, 16'hC222, 16'hB111, 16'hA000};
        req = 4'b1011;
        for (int c = 0; c < 16; c++) begin
            tick();
            checks++;
            if (grant !== exp_g[c] || busy !== 1'b1) begin
                failures++;
                $display("FAIL rotation_c%0d got=%b/%b exp=%b/1", c, grant, busy, exp_g[c]);
            end
            if (c == 5) begin
                checks++;
                if (hex_all !== 16'hB111) begin failures++; $display("FAIL rotation_hex got=%h exp=b111", hex_all); end
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_dwell();
        do_reset();
        val[15:0] = 16'hBEEF;
        dp[3:0]   = 4'b1010;
        req = 4'b0001;
        tick();
        req = 4'b0000;
        for (int c = 1; c < 4; c++) begin
            tick();
            checks++;
            if (grant !== 4'b0001) begin failures++; $display("FAIL dwell_hold_c%0d got=%b exp=0001", c, grant); end
        end
        checks++;
`ifdef SSEG_ARB_SRC_DP_EN
        if (dp_out !== 4'b0111) begin failures++; $display("FAIL dwell_dp got=%b exp=0111", dp_out); end
`else
        if (dp_out !== 4'b1010) begin failures++; $display("FAIL dwell_dp got=%b exp=1010", dp_out); end
`endif
        tick();
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            failures++; $display("FAIL dwell_idle got=%b/%b exp=0000/0", grant, busy);
        end
        val[15:0] = 16'h1234;
        tick();
        checks++;
        if (hex_all !== 16'hBEEF) begin failures++; $display("FAIL dwell_idle_hex got=%h exp=beef", hex_all); end
    endtask

    task automatic test_preempt_keep();
        do_reset();
        val[47:32] = 16'h0C0D;
        dp[11:8]   = 4'b0011;
        req = 4'b0100;
        repeat (6) tick();
        checks++;
        if (grant !== 4'b0100 || busy !== 1'b1) begin
            failures++; $display("FAIL keep_owner got=%b/%b exp=0100/1", grant, busy);
        end
        checks++;
`ifdef SSEG_ARB_SRC_DP_EN
        if (dp_out !== 4'b0101) begin failures++; $display("FAIL keep_dp got=%b exp=0101", dp_out); end
`else
        if (dp_out !== 4'b0011) begin failures++; $display("FAIL keep_dp got=%b exp=0011", dp_out); end
`endif
        req = 4'b0101;
        tick();
        checks++;
        if (grant !== 4'b0001) begin failures++; $display("FAIL preempt_grant got=%b exp=0001", grant); end
        for (int c = 1; c < 4; c++) begin
            tick();
            checks++;
            if (grant !== 4'b0001) begin failures++; $display("FAIL preempt_dwell_c%0d got=%b exp=0001", c, grant); end
        end
        tick();
        checks++;
        if (grant !== 4'b0100) begin failures++; $display("FAIL preempt_back got=%b exp=0100", grant); end
    endtask

    task automatic test_reset_mid_grant();
        reset_n = 1'b0;
        #2;
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            failures++; $display("FAIL midreset_grant got=%b/%b exp=0000/0", grant, busy);
        end
        checks++;
        if (hex_all !== 16'h0000 || dp_out !== 4'b1111) begin
            failures++; $display("FAIL midreset_disp got=%h/%b exp=0000/1111", hex_all, dp_out);
        end
        tick();
        reset_n = 1'b1;
        req = 4'b0000;
        tick();
    endtask

    task automatic test_dp_owner3();
        do_reset();
        dp = 16'h6A5C;
        req = 4'b1000;
        tick();
        tick();
        checks++;
`ifdef SSEG_ARB_SRC_DP_EN
        if (dp_out !== 4'b0100) begin failures++; $display("FAIL dp_owner3 got=%b exp=0100", dp_out); end
`else
        if (dp_out !== 4'b0110) begin failures++; $display("FAIL dp_owner3 got=%b exp=0110", dp_out); end
`endif
        req = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_dwell();
        test_preempt_keep();
        test_reset_mid_grant();
        test_dp_owner3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
